// File: rtl/cmd_dispatcher.sv
// UART command dispatcher: maps a received command byte to one worker unit,
// holds its activate line until done/timeout/abort, and queues a one-byte status reply.
module cmd_dispatcher #(
  parameter int unsigned          N_UNITS        = 4,
  parameter logic [63:0]          UNIT_CODES     = 64'h0000_0000_2322_2111,
  parameter int unsigned          TIMEOUT_WIDTH  = 26,
  parameter int unsigned          TIMEOUT_CYCLES = 50_000_000
) (
  input  logic               clk_50mhz,
  input  logic               reset,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  input  logic [N_UNITS-1:0] done,
  output logic [N_UNITS-1:0] activate,
  input  logic               tx_active,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  output logic [7:0]         state,
  output logic               busy
);

  localparam logic [7:0] REP_OK    = 8'h4F;
  localparam logic [7:0] REP_UNK   = 8'h3F;
  localparam logic [7:0] REP_TOUT  = 8'h54;
  localparam logic [7:0] REP_ABORT = 8'h41;
  localparam logic [7:0] REP_BUSY  = 8'h42;

  localparam bit                     WD_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_WIDTH-1:0] WD_LIM =
    WD_EN ? TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_t;

  fsm_t                     r_fsm, w_fsm_n;
  logic [N_UNITS-1:0]       r_activate, w_activate_n;
  logic [7:0]               r_code, w_code_n;
  logic [TIMEOUT_WIDTH-1:0] r_wd, w_wd_n;

  logic                     r_pend;
  logic [7:0]               r_pend_byte;
  logic                     r_tx_start;
  logic [7:0]               r_tx_data;

  logic                     w_rep_load;
  logic                     w_rep_is_b;
  logic [7:0]               w_rep_byte;

  logic                     w_hit;
  logic [N_UNITS-1:0]       w_hit_oh;
  logic                     w_done_hit;

  // Lowest-index match wins so duplicate codes can never produce a multi-hot activate.
  always_comb begin
    w_hit    = 1'b0;
    w_hit_oh = '0;
    for (int unsigned i = 0; i < N_UNITS; i++) begin
      if (!w_hit && (rx_data == UNIT_CODES[8*i +: 8])) begin
        w_hit       = 1'b1;
        w_hit_oh[i] = 1'b1;
      end
    end
  end

  assign w_done_hit = |(done & r_activate);

  always_ff @(posedge clk_50mhz) begin
    if (!reset) begin
      r_fsm      <= IDLE;
      r_activate <= '0;
      r_code     <= '0;
      r_wd       <= '0;
    end else begin
      r_fsm      <= w_fsm_n;
      r_activate <= w_activate_n;
      r_code     <= w_code_n;
      r_wd       <= w_wd_n;
    end
  end

  always_comb begin
    w_fsm_n      = r_fsm;
    w_activate_n = r_activate;
    w_code_n     = r_code;
    w_wd_n       = r_wd;
    w_rep_load   = 1'b0;
    w_rep_is_b   = 1'b0;
    w_rep_byte   = '0;

    unique case (r_fsm)
      IDLE: begin
        if (rx_valid && (rx_data != 8'h00)) begin
          if (w_hit) begin
            w_fsm_n      = RUN;
            w_activate_n = w_hit_oh;
            w_code_n     = rx_data;
            w_wd_n       = '0;
          end else begin
            w_rep_load = 1'b1;
            w_rep_byte = REP_UNK;
          end
        end
      end

      RUN: begin
        if (w_done_hit) begin
          w_rep_load = 1'b1;
          w_rep_byte = REP_OK;
        end else if (WD_EN && (r_wd == WD_LIM)) begin
          w_rep_load = 1'b1;
          w_rep_byte = REP_TOUT;
        end else if (rx_valid && (rx_data == 8'h00)) begin
          w_rep_load = 1'b1;
          w_rep_byte = REP_ABORT;
        end else begin
          if (rx_valid) begin
            w_rep_load = 1'b1;
            w_rep_is_b = 1'b1;
            w_rep_byte = REP_BUSY;
          end
          if (r_wd != '1) begin
            w_wd_n = r_wd + 1'b1;
          end
        end

        if (w_rep_load && !w_rep_is_b) begin
          w_fsm_n      = IDLE;
          w_activate_n = '0;
          w_code_n     = '0;
        end
      end

      default: w_fsm_n = IDLE;
    endcase
  end

  // The slot stays occupied through the tx_start cycle and empties on the following edge;
  // only a busy reply respects occupancy, every other reply overwrites the slot.
  always_ff @(posedge clk_50mhz) begin
    if (!reset) begin
      r_pend      <= 1'b0;
      r_pend_byte <= '0;
      r_tx_start  <= 1'b0;
      r_tx_data   <= '0;
    end else begin
      r_tx_start <= 1'b0;
      if (w_rep_load && !(w_rep_is_b && r_pend)) begin
        r_pend      <= 1'b1;
        r_pend_byte <= w_rep_byte;
      end else if (r_tx_start) begin
        r_pend <= 1'b0;
      end else if (r_pend && !tx_active) begin
        r_tx_start <= 1'b1;
        r_tx_data  <= r_pend_byte;
      end
    end
  end

  assign activate = r_activate;
  assign state    = r_code;
  assign busy     = (r_fsm == RUN);
  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;

endmodule
